// File: rtl/rv32i_mmu.sv
// Memory management unit between the multicycle RV32I core and its targets:
// region decode, sub-word access with RAM read-modify-write, peripheral timeout.
module rv32i_mmu #(
    parameter int          RAM_L       = 65536,
    parameter int          N_PERIPH    = 4,
    parameter logic [31:0] PERIPH_BASE = 32'hF000_0000,
    parameter int          PERIPH_SPAN = 256,
    parameter int          TIMEOUT     = 15
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           core_req,
    input  logic [31:0]                    core_addr,
    input  logic                           core_wr_ena,
    input  logic [1:0]                     core_size,
    input  logic                           core_unsigned,
    input  logic [31:0]                    core_wr_data,
    output logic                           core_ack,
    output logic [31:0]                    core_rd_data,
    output logic                           core_err,
    output logic [31:0]                    err_addr,
    output logic [7:0]                     err_count,
    output logic [$clog2(RAM_L)-1:0]       ram_addr,
    output logic                           ram_wr_ena,
    output logic [31:0]                    ram_wr_data,
    input  logic [31:0]                    ram_rd_data,
    output logic [N_PERIPH-1:0]            periph_req,
    output logic [$clog2(PERIPH_SPAN)-1:0] periph_addr,
    output logic                           periph_wr_ena,
    output logic [3:0]                     periph_wstrb,
    output logic [31:0]                    periph_wr_data,
    input  logic [N_PERIPH-1:0]            periph_ack,
    input  logic [32*N_PERIPH-1:0]         periph_rd_data
);

    localparam int RAM_AW = $clog2(RAM_L);
    localparam int PAW    = $clog2(PERIPH_SPAN);
    localparam int CW     = (N_PERIPH > 1) ? $clog2(N_PERIPH) : 1;
    localparam int TW     = $clog2(TIMEOUT + 1);

    localparam logic [32:0] RAM_BYTES    = 33'(4 * RAM_L);
    localparam logic [31:0] PERIPH_BYTES = 32'(N_PERIPH * PERIPH_SPAN);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RAM_RD = 3'd1;
    localparam logic [2:0] S_RAM_WR = 3'd2;
    localparam logic [2:0] S_PERIPH = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    logic [2:0]    state;
    logic [31:0]   addr_q;
    logic [1:0]    size_q;
    logic          uns_q;
    logic          wr_q;
    logic [3:0]    wstrb_q;
    logic [31:0]   data_q;
    logic          err_q;
    logic [CW-1:0] chan_q;
    logic [TW-1:0] tmo_q;

    logic [1:0]    lane_in;
    logic [3:0]    wstrb_in;
    logic          misaligned;
    logic [31:0]   poff;
    logic          ram_hit;
    logic          periph_hit;
    logic [CW-1:0] chan_in;
    logic [31:0]   merged;
    logic [31:0]   shifted;
    logic [31:0]   load_ext;
    logic          ack_sel;
    logic [31:0]   chan_rd;

    // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        lane_in  = core_addr[1:0];
        wstrb_in = 4'b1111;
        case (core_size)
            2'd0:    wstrb_in = 4'b0001 << lane_in;
            2'd1:    wstrb_in = 4'b0011 << lane_in;
            default: wstrb_in = 4'b1111;
        endcase
        misaligned = (core_size == 2'd3)
                   || (core_size == 2'd1 && core_addr[0])
                   || (core_size == 2'd2 && lane_in != 2'd0);
        poff       = core_addr - PERIPH_BASE;
        // RAM wins any overlap, so an address inside RAM never aliases a channel.
        ram_hit    = {1'b0, core_addr} < RAM_BYTES;
        periph_hit = (core_addr >= PERIPH_BASE) && (poff < PERIPH_BYTES);
        chan_in    = poff[PAW+CW-1:PAW];
    end

    // Store data is pre-shifted onto its lanes at capture, so the merge is a per-byte select.
    always_comb begin
        merged = ram_rd_data;
        for (int b = 0; b < 4; b++) begin
            if (wstrb_q[b]) merged[8*b +: 8] = data_q[8*b +: 8];
        end
    end

    always_comb begin
        shifted  = data_q >> {addr_q[1:0], 3'b000};
        load_ext = shifted;
        case (size_q)
            2'd0:    load_ext = uns_q ? {24'b0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
            2'd1:    load_ext = uns_q ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
        ack_sel = periph_ack[chan_q];
        chan_rd = periph_rd_data[{chan_q, 5'b00000} +: 32];
    end

    always_comb begin
        core_ack       = (state == S_RESP);
        core_err       = (state == S_RESP) && err_q;
        core_rd_data   = (state == S_RESP && !err_q && !wr_q) ? load_ext : 32'b0;
        ram_addr       = '0;
        // Reset asserted mid-write cancels the strobe so an abandoned store never lands.
        ram_wr_ena     = (state == S_RAM_WR) && rst;
        ram_wr_data    = '0;
        periph_req     = '0;
        periph_addr    = '0;
        periph_wr_ena  = 1'b0;
        periph_wstrb   = 4'b0;
        periph_wr_data = 32'b0;
        if (state == S_RAM_RD || state == S_RAM_WR) begin
            ram_addr = addr_q[RAM_AW+1:2];
        end
        if (state == S_RAM_WR) begin
            ram_wr_data = data_q;
        end
        if (state == S_PERIPH) begin
            for (int i = 0; i < N_PERIPH; i++) begin
                periph_req[i] = (chan_q == CW'(i));
            end
            periph_addr    = addr_q[PAW-1:0];
            periph_wr_ena  = wr_q;
            periph_wstrb   = wstrb_q;
            periph_wr_data = data_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            addr_q    <= '0;
            size_q    <= '0;
            uns_q     <= 1'b0;
            wr_q      <= 1'b0;
            wstrb_q   <= '0;
            data_q    <= '0;
            err_q     <= 1'b0;
            chan_q    <= '0;
            tmo_q     <= '0;
            err_addr  <= '0;
            err_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (core_req) begin
                        addr_q  <= core_addr;
                        size_q  <= core_size;
                        uns_q   <= core_unsigned;
                        wr_q    <= core_wr_ena;
                        wstrb_q <= wstrb_in;
                        data_q  <= core_wr_data << {lane_in, 3'b000};
                        chan_q  <= chan_in;
                        tmo_q   <= '0;
                        err_q   <= 1'b0;
                        if (misaligned || (!ram_hit && !periph_hit)) begin
                            err_q <= 1'b1;
                            state <= S_RESP;
                        end else if (ram_hit) begin
                            state <= (core_wr_ena && core_size == 2'd2) ? S_RAM_WR : S_RAM_RD;
                        end else begin
                            state <= S_PERIPH;
                        end
                    end
                end
                S_RAM_RD: begin
                    data_q <= wr_q ? merged : ram_rd_data;
                    state  <= wr_q ? S_RAM_WR : S_RESP;
                end
                S_RAM_WR: state <= S_RESP;
                S_PERIPH: begin
                    // An ack arriving on the expiry cycle still counts as success.
                    if (ack_sel) begin
                        data_q <= chan_rd;
                        state  <= S_RESP;
                    end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                        err_q <= 1'b1;
                        state <= S_RESP;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                    if (err_q) begin
                        err_addr <= addr_q;
                        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_mmu.sv
// Directed bench for rv32i_mmu: RAM model, scripted peripheral responder,
// hand-computed expectations checked with immediate assertions.
module tb_rv32i_mmu;

    localparam int RAM_L = 65536;

    logic         clk = 1'b0;
    logic         rst;
    logic         core_req;
    logic [31:0]  core_addr;
    logic         core_wr_ena;
    logic [1:0]   core_size;
    logic         core_unsigned;
    logic [31:0]  core_wr_data;
    logic         core_ack;
    logic [31:0]  core_rd_data;
    logic         core_err;
    logic [31:0]  err_addr;
    logic [7:0]   err_count;
    logic [15:0]  ram_addr;
    logic         ram_wr_ena;
    logic [31:0]  ram_wr_data;
    logic [31:0]  ram_rd_data;
    logic [3:0]   periph_req;
    logic [7:0]   periph_addr;
    logic         periph_wr_ena;
    logic [3:0]   periph_wstrb;
    logic [31:0]  periph_wr_data;
    logic [3:0]   periph_ack = 4'b0;
    logic [127:0] periph_rd_data;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [RAM_L];
    int          wr_cnt = 0;
    logic [15:0] last_wr_addr = '0;

    int          resp_delay = 0;
    int          resp_chan  = 0;
    logic        resp_en    = 1'b0;
    int          req_cycles = 0;
    int          req_total  = 0;
    logic [3:0]  snap_req;
    logic [7:0]  snap_addr;
    logic [3:0]  snap_wstrb;
    logic [31:0] snap_wdata;
    logic        unstable;

    rv32i_mmu dut (
        .clk            (clk),
        .rst            (rst),
        .core_req       (core_req),
        .core_addr      (core_addr),
        .core_wr_ena    (core_wr_ena),
        .core_size      (core_size),
        .core_unsigned  (core_unsigned),
        .core_wr_data   (core_wr_data),
        .core_ack       (core_ack),
        .core_rd_data   (core_rd_data),
        .core_err       (core_err),
        .err_addr       (err_addr),
        .err_count      (err_count),
        .ram_addr       (ram_addr),
        .ram_wr_ena     (ram_wr_ena),
        .ram_wr_data    (ram_wr_data),
        .ram_rd_data    (ram_rd_data),
        .periph_req     (periph_req),
        .periph_addr    (periph_addr),
        .periph_wr_ena  (periph_wr_ena),
        .periph_wstrb   (periph_wstrb),
        .periph_wr_data (periph_wr_data),
        .periph_ack     (periph_ack),
        .periph_rd_data (periph_rd_data)
    );

    always #5 clk = ~clk;

    assign ram_rd_data    = mem[ram_addr];
    assign periph_rd_data = {32'h4444_4444, 32'h1234_5678, 32'h2222_2222, 32'h1111_1111};

    always @(posedge clk) begin
        if (ram_wr_ena) begin
            mem[ram_addr] <= ram_wr_data;
            wr_cnt        <= wr_cnt + 1;
            last_wr_addr  <= ram_addr;
        end
    end

    // Peripheral responder: acks channel resp_chan in the resp_delay-th cycle of a request.
    always @(negedge clk) begin
        if (periph_req != 4'b0) begin
            req_cycles = req_cycles + 1;
            req_total  = req_total + 1;
            if (req_cycles == 1) begin
                snap_req   = periph_req;
                snap_addr  = periph_addr;
                snap_wstrb = periph_wstrb;
                snap_wdata = periph_wr_data;
            end else if (periph_req != snap_req || periph_addr != snap_addr
                         || periph_wstrb != snap_wstrb || periph_wr_data != snap_wdata) begin
                unstable = 1'b1;
            end
            periph_ack = (resp_en && req_cycles == resp_delay) ? (4'b0001 << resp_chan) : 4'b0;
        end else begin
            req_cycles = 0;
            periph_ack = 4'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one access at a negedge in IDLE; lat is the cycle of core_ack (0 if never seen).
    task automatic xfer(input logic wr, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat);
        core_req      = 1'b1;
        core_wr_ena   = wr;
        core_size     = size;
        core_unsigned = uns;
        core_addr     = addr;
        core_wr_data  = wdata;
        unstable      = 1'b0;
        req_total     = 0;
        lat           = 0;
        rdata         = 32'hxxxx_xxxx;
        err           = 1'bx;
        @(posedge clk);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (core_ack) begin
                lat   = c;
                rdata = core_rd_data;
                err   = core_err;
                break;
            end
        end
        core_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          wc0;
        int          bad;

        rst = 1'b0; core_req = 1'b0; core_addr = '0; core_wr_ena = 1'b0;
        core_size = '0; core_unsigned = 1'b0; core_wr_data = '0; unstable = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_core_ack", core_ack, 0);
        check("rst_rd_data", core_rd_data, 0);
        check("rst_err_count", err_count, 0);
        check("rst_periph_req", periph_req, 0);
        check("rst_ram_wr_ena", ram_wr_ena, 0);
        rst = 1'b1;
        @(negedge clk);

        // Word store then word load at 0x100.
        wc0 = wr_cnt;
        xfer(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEAD_BEEF, rd, er, lat);
        check("wst_latency", lat, 2);
        check("wst_err", er, 0);
        check("wst_rd_zero", rd, 0);
        check("wst_one_write", wr_cnt - wc0, 1);
        check("wst_ram_addr", last_wr_addr, 32'h40);
        xfer(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, rd, er, lat);
        check("wld_latency", lat, 2);
        check("wld_data", rd, 32'hDEAD_BEEF);
        check("wld_err", er, 0);

        // Byte store over the word, then sub-word loads.
        xfer(1'b1, 2'd0, 1'b0, 32'h102, 32'h0000_005A, rd, er, lat);
        check("bst_latency", lat, 3);
        check("bst_merged", mem[16'h40], 32'hDE5A_BEEF);
        xfer(1'b0, 2'd0, 1'b0, 32'h102, 32'h0, rd, er, lat);
        check("lb_data", rd, 32'h0000_005A);
        xfer(1'b0, 2'd1, 1'b1, 32'h102, 32'h0, rd, er, lat);
        check("lhu_data", rd, 32'h0000_DE5A);
        xfer(1'b0, 2'd1, 1'b0, 32'h102, 32'h0, rd, er, lat);
        check("lh_data", rd, 32'hFFFF_DE5A);
        xfer(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, rd, er, lat);
        check("lbu_top_lane", rd, 32'h0000_00DE);

        // Misaligned accesses.
        wc0 = wr_cnt;
        xfer(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, rd, er, lat);
        check("mis_word_latency", lat, 1);
        check("mis_word_err", er, 1);
        check("mis_word_rd_zero", rd, 0);
        xfer(1'b1, 2'd1, 1'b0, 32'h003, 32'hFFFF, rd, er, lat);
        check("mis_half_err", er, 1);
        check("mis_no_write", wr_cnt - wc0, 0);
        check("mis_err_count", err_count, 2);
        check("mis_err_addr", err_addr, 32'h003);

        // RAM upper boundary and first unmapped word above it.
        xfer(1'b1, 2'd2, 1'b0, 32'h0003_FFFC, 32'hCAFE_F00D, rd, er, lat);
        check("ram_top_write_addr", last_wr_addr, 32'hFFFF);
        xfer(1'b0, 2'd2, 1'b0, 32'h0003_FFFC, 32'h0, rd, er, lat);
        check("ram_top_load", rd, 32'hCAFE_F00D);
        xfer(1'b0, 2'd2, 1'b0, 32'h0004_0000, 32'h0, rd, er, lat);
        check("ram_above_err", er, 1);
        check("ram_above_latency", lat, 1);

        // Peripheral byte store on channel 1, acked in its third cycle.
        resp_en = 1'b1; resp_chan = 1; resp_delay = 3;
        xfer(1'b1, 2'd0, 1'b0, 32'hF000_0103, 32'h0000_00A5, rd, er, lat);
        check("pst_req", snap_req, 32'b0010);
        check("pst_addr", snap_addr, 32'h03);
        check("pst_wstrb", snap_wstrb, 32'b1000);
        check("pst_wdata", snap_wdata, 32'hA500_0000);
        check("pst_stable", unstable, 0);
        check("pst_latency", lat, 4);
        check("pst_err", er, 0);

        // Channel 2 load with no ack times out.
        resp_en = 1'b0;
        xfer(1'b0, 2'd2, 1'b0, 32'hF000_0200, 32'h0, rd, er, lat);
        check("tmo_req_cycles", req_total, 15);
        check("tmo_latency", lat, 16);
        check("tmo_err", er, 1);
        check("tmo_err_addr", err_addr, 32'hF000_0200);

        // Ack on the expiry cycle succeeds.
        resp_en = 1'b1; resp_chan = 2; resp_delay = 15;
        xfer(1'b0, 2'd2, 1'b0, 32'hF000_0200, 32'h0, rd, er, lat);
        check("exp_ack_latency", lat, 16);
        check("exp_ack_err", er, 0);
        check("exp_ack_data", rd, 32'h1234_5678);

        // Ack on a non-selected channel is ignored.
        resp_chan = 1; resp_delay = 3;
        xfer(1'b0, 2'd2, 1'b0, 32'hF000_0200, 32'h0, rd, er, lat);
        check("wrong_chan_err", er, 1);
        check("wrong_chan_latency", lat, 16);

        // Peripheral window beyond the last channel is unmapped.
        resp_en = 1'b0;
        xfer(1'b0, 2'd2, 1'b0, 32'hF000_0400, 32'h0, rd, er, lat);
        check("beyond_periph_err", er, 1);
        check("beyond_periph_no_req", req_total, 0);

        // Reset during PERIPH_WAIT.
        core_req = 1'b1; core_wr_ena = 1'b0; core_size = 2'd2; core_addr = 32'hF000_0000;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        check("prst_req_before", periph_req, 32'b0001);
        rst = 1'b0; core_req = 1'b0;
        @(posedge clk); @(negedge clk);
        check("prst_req_after", periph_req, 0);
        check("prst_periph_addr", periph_addr, 0);
        check("prst_err_count", err_count, 0);
        check("prst_err_addr", err_addr, 0);
        check("prst_core_ack", core_ack, 0);
        rst = 1'b1;
        @(negedge clk);

        // Reset during RAM_WR of a sub-word store.
        wc0 = wr_cnt;
        core_req = 1'b1; core_wr_ena = 1'b1; core_size = 2'd0; core_addr = 32'h100;
        core_wr_data = 32'h77;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        check("rrst_in_write", ram_wr_ena, 1);
        rst = 1'b0; core_req = 1'b0;
        #1;
        check("rrst_strobe_cut", ram_wr_ena, 0);
        @(posedge clk); @(negedge clk);
        check("rrst_no_write", wr_cnt - wc0, 0);
        check("rrst_mem_kept", mem[16'h40], 32'hDE5A_BEEF);
        check("rrst_ram_addr", ram_addr, 0);
        check("rrst_ram_wr_data", ram_wr_data, 0);
        rst = 1'b1;
        @(negedge clk);

        // 256 errors saturate the counter.
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            xfer(1'b0, 2'd2, 1'b0, 32'h8000_0000 + 32'(i * 4), 32'h0, rd, er, lat);
            if (er !== 1'b1) bad++;
        end
        check("sat_all_errored", bad, 0);
        check("sat_err_count", err_count, 32'hFF);
        check("sat_err_addr", err_addr, 32'h8000_03FC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rv32i_mmu.md
Name: rv32i_mmu

Overview:
- Memory management unit placed between the multicycle RV32I core and its memory targets. Replaces bare address truncation with:
  - region decode: word RAM, N memory-mapped peripheral channels, unmapped space;
  - byte and halfword loads/stores, with read-modify-write on the word-only RAM;
  - a req/ack handshake toward the core, with per-channel peripheral timeout and error reporting.

Parameters:
- RAM_L, 65536, RAM depth in 32-bit words; RAM occupies byte addresses 0 .. 4*RAM_L-1.
- N_PERIPH, 4, number of peripheral channels.
- PERIPH_BASE, 32'hF000_0000, byte base of channel 0.
- PERIPH_SPAN, 256, bytes per channel (power of two); channel i at PERIPH_BASE + i*PERIPH_SPAN.
- TIMEOUT, 15, cycles to wait for periph_ack before erroring.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- core_req  in  1  request valid; held by core until core_ack.
- core_addr  in  32  byte address.
- core_wr_ena  in  1  1 = store, 0 = load.
- core_size  in  2  0 byte, 1 half, 2 word (3 treated as misaligned error).
- core_unsigned  in  1  zero-extend sub-word loads.
- core_wr_data  in  32  store data, right-aligned.
- core_ack  out  1  one-cycle response strobe.
- core_rd_data  out  32  load result, valid when core_ack.
- core_err  out  1  valid when core_ack; misaligned, unmapped or timeout.
- err_addr  out  32  address of most recent errored access.
- err_count  out  8  saturating error counter.
- ram_addr  out  $clog2(RAM_L)  word index.
- ram_wr_ena  out  1  RAM write strobe.
- ram_wr_data  out  32  RAM write word.
- ram_rd_data  in  32  combinational RAM read data.
- periph_req  out  N_PERIPH  one-hot request, held until ack or timeout.
- periph_addr  out  $clog2(PERIPH_SPAN)  byte offset within channel.
- periph_wr_ena  out  1  store.
- periph_wstrb  out  4  byte lanes.
- periph_wr_data  out  32  lane-shifted store data.
- periph_ack  in  N_PERIPH  per-channel completion.
- periph_rd_data  in  32*N_PERIPH  channel i at bits [32i+31:32i].

Behaviour:
- Reset (rst=0 at clk edge):
  - state IDLE;
  - all outputs 0 (core_ack, core_err, core_rd_data, err_addr, err_count, ram_*, periph_*);
  - any in-flight access is abandoned; periph_req drops the cycle after reset is sampled.
- States: IDLE, RAM_RD, RAM_WR, PERIPH_WAIT, RESP.
- IDLE:
  - on core_req, capture addr/size/unsigned/wr_data/wr_ena;
  - compute lane = addr[1:0];
  - compute wstrb: byte 4'b0001<<lane, half 4'b0011<<lane, word 4'b1111;
  - decode and branch:
    - misaligned (half with addr[0]=1; word with lane!=0; size 3) -> RESP with err;
    - RAM hit -> RAM_RD, or RAM_WR for a word store;
    - peripheral hit -> PERIPH_WAIT;
    - otherwise -> RESP with err.
  - Errors never touch RAM or peripherals.
  - core_req is sampled only in IDLE.
- RAM_RD:
  - ram_addr = addr[$clog2(RAM_L)+1:2]; capture ram_rd_data;
  - load -> RESP; sub-word store -> RAM_WR with merged word: old bytes where wstrb=0, wr_data<<(8*lane) where wstrb=1.
- RAM_WR: ram_wr_ena=1 for exactly one cycle with full or merged word -> RESP.
- PERIPH_WAIT:
  - periph_req[i]=1 with stable addr/wstrb/data; timeout counter increments each cycle;
  - periph_ack[i] seen -> capture channel data, drop req next cycle, -> RESP;
  - counter reaches TIMEOUT with no ack -> RESP with err;
  - ack in the same cycle as expiry counts as success;
  - ack on a non-selected channel is ignored.
- RESP:
  - core_ack=1 for one cycle; -> IDLE;
  - load data = word >> (8*lane), then sign- or zero-extended to 32 bits per size/unsigned;
  - stores and errors return rd_data=0;
  - on err: err_addr<=addr; err_count increments, saturating at 255.
- Latency, req accepted in cycle 0 to core_ack:
  - RAM load and RAM word store: cycle 2;
  - RAM sub-word store: cycle 3;
  - error: cycle 1;
  - peripheral: ack cycle + 1.
- Decode rules:
  - RAM decode uses the full 32-bit address;
  - addresses in RAM range wrap to no other region;
  - peripheral window above PERIPH_BASE + N_PERIPH*PERIPH_SPAN is unmapped.

Test Plan:
- Word store 0xDEADBEEF @0x100, then word load @0x100 -> one ram_wr_ena pulse with ram_addr=0x40; load acks in cycle 2 with 0xDEADBEEF, core_err=0.
- Byte store 0x5A @0x102 over 0xDEADBEEF, then signed byte load @0x102 and unsigned half load @0x102 -> RAM holds 0xDE5ABEEF; loads return 0x0000005A and 0x0000DE5A; signed half load @0x102 returns 0xFFFFDE5A; store acks in cycle 3.
- Word load @0x101, then half store @0x003 -> core_err=1 at cycle 1, no RAM write, err_count=2, err_addr=0x003.
- Byte store 0xA5 @0xF000_0103 with periph_ack[1] after 3 cycles -> periph_req=4'b0010, periph_addr=0x03, wstrb=4'b1000, wr_data=0xA5000000; core_ack one cycle after periph_ack.
- Load @0xF000_0200 with no ack -> req held 15 cycles, then core_err=1; separately, an ack on expiry cycle 15 returns data with err=0.
- rst=0 asserted during PERIPH_WAIT and during RAM_WR of a sub-word store -> periph_req and all outputs 0 next cycle, no RAM write; 256 further errors leave err_count=255.
